inst_axi_rd_bridge: RTL and testbench
=====================================

Name: inst_axi_rd_bridge

Overview:
- Instruction-side bus bridge directly downstream of the fetch stage's inst_sram-like port.
- Accepts fetch requests using the req/addr_ok/data_ok handshake and converts them into AXI4 single-beat read transactions.
- Returns read data in order.
- Supports a bounded number of outstanding reads, so pre-IF can issue the next address while IF still waits for data.

Parameters:
- MAX_OUTSTANDING, 2, maximum accepted-but-not-returned reads (1..7).
- AXI_ID, 4'h0, constant ARID driven on every read.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- inst_sram_req  in  1  fetch request valid.
- inst_sram_wr  in  1  write flag; must be 0 for fetch.
- inst_sram_size  in  2  request size; ignored.
- inst_sram_wstrb  in  4  ignored.
- inst_sram_addr  in  32  physical fetch address.
- inst_sram_wdata  in  32  ignored.
- inst_sram_addr_ok  out  1  request accepted this cycle.
- inst_sram_data_ok  out  1  read data valid this cycle.
- inst_sram_rdata  out  32  read data.
- arid  out  4  read ID; always AXI_ID.
- araddr  out  32  read address.
- arlen  out  8  burst length; constant 0.
- arsize  out  3  transfer size; constant 3'b010.
- arburst  out  2  burst type; constant 2'b01.
- arlock  out  2  constant 0.
- arcache  out  4  constant 0.
- arprot  out  3  constant 0.
- arvalid  out  1  AR channel valid.
- arready  in  1  AR channel ready.
- rid  in  4  read ID; not checked.
- rdata  in  32  read data.
- rresp  in  2  read response; ignored.
- rlast  in  1  last beat; always 1 for single-beat reads.
- rvalid  in  1  R channel valid.
- rready  out  1  R channel ready.

Behaviour:
- Reset: synchronous on clk when resetn=0.
  - Reset values: arvalid=0, araddr=0, outstanding count=0, rready=0.
  - addr_ok=0 and data_ok=0 during reset.
  - Any in-flight transaction is dropped with no response.
- rready:
  - Registered; becomes 1 the first cycle after reset deassertion and stays 1.
  - The fetch stage always consumes data_ok, so there is no R backpressure.
- AR slot availability: ar_free = ~arvalid | arready.
- Accept condition: inst_sram_addr_ok = inst_sram_req & ~inst_sram_wr & ar_free & (cnt < MAX_OUTSTANDING) & rready.
  - This is combinational, in the same cycle as req.
- On accept:
  - araddr <= inst_sram_addr.
  - arvalid <= 1 at the next edge.
- AR hold:
  - arvalid and araddr are held stable until arready.
  - On arready with no new accept, arvalid <= 0.
  - Back-to-back accepts are allowed when arready=1 (pipelined AR).
- Response path (combinational pass-through):
  - inst_sram_data_ok = rvalid & rready.
  - inst_sram_rdata = rdata.
- Outstanding counter cnt, width clog2(MAX_OUTSTANDING+1):
  - +1 on addr_ok.
  - -1 on rvalid & rready & rlast.
  - Both in the same cycle: unchanged.
- Full: when cnt == MAX_OUTSTANDING, addr_ok=0 even if the AR slot is free.
  - A response in that same cycle does not unblock acceptance; acceptance resumes the next cycle.
- Stray response: an R handshake with cnt==0 must not underflow; cnt stays 0 and data_ok is still asserted.
- Writes: a request with inst_sram_wr=1 is never accepted (addr_ok stays 0); no AXI traffic is generated.
- Latency:
  - Accept at cycle T → arvalid=1 at T+1.
  - With arready=1 at T+1 and rvalid=1 at T+2, data_ok=1 at T+2.
- Cancelled fetches: discarding stale fetches is the fetch stage's job. The bridge returns every accepted read exactly once, in AR order.

Test Plan:
- Single fetch:
  - Stimulus: reset 3 cycles; req=1 with addr=0x1C000000 at T, arready=1, rvalid=1 with rdata=0x02800000 at T+2.
  - Response: addr_ok=1 at T; arvalid=1 and araddr=0x1C000000 at T+1; data_ok=1 and rdata=0x02800000 at T+2; cnt returns to 0.
- AR stall:
  - Stimulus: arready=0 for 4 cycles after accept of 0x1C000004.
  - Response: arvalid and araddr held 4 cycles; addr_ok=0 for new reqs until arready=1.
- Full:
  - Stimulus: MAX_OUTSTANDING=2; accept 0x1C000000 and 0x1C000004; no R.
  - Response: third req held with addr_ok=0; two R beats return 0xA, 0xB; data_ok twice in order; third req accepted the cycle after cnt<2.
- Simultaneous accept and response:
  - Stimulus: cnt=1; addr_ok and an R handshake in the same cycle.
  - Response: cnt stays 1.
- Reset mid-operation:
  - Stimulus: resetn=0 with arvalid=1 and cnt=2.
  - Response: next cycle arvalid=0, cnt=0, addr_ok=0; a fresh fetch works normally after release.
- Write rejection:
  - Stimulus: req=1 with wr=1 for 5 cycles.
  - Response: addr_ok=0 and arvalid=0 throughout.

Source files
------------

// File: rtl/inst_axi_rd_bridge.sv
// Instruction fetch bridge: turns sram-like req/addr_ok/data_ok fetches into
// single-beat AXI4 reads, with a bounded number of outstanding reads.
module inst_axi_rd_bridge #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [3:0]  AXI_ID          = 4'h0
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    logic [CW-1:0] cnt;
    logic          ar_free;
    logic          accept;
    logic          r_hs;
    logic          r_retire;
    logic          unused_inputs;

    assign unused_inputs = ^{inst_sram_size, inst_sram_wstrb, inst_sram_wdata, rid, rresp};

    assign arid    = AXI_ID;
    assign arlen   = 8'd0;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    // Gating with resetn keeps the handshakes quiet for the whole reset window.
    assign ar_free  = ~arvalid | arready;
    assign accept   = resetn & inst_sram_req & ~inst_sram_wr & ar_free
                    & (cnt < CNT_MAX) & rready;
    assign r_hs     = resetn & rvalid & rready;
    assign r_retire = r_hs & rlast & (cnt != '0);

    assign inst_sram_addr_ok = accept;
    assign inst_sram_data_ok = r_hs;
    assign inst_sram_rdata   = rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rready <= 1'b0;
        end else begin
            rready <= 1'b1;
        end
    end

    // AR channel: load on accept, hold until the slave takes it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            arvalid <= 1'b0;
            araddr  <= 32'd0;
        end else if (accept) begin
            arvalid <= 1'b1;
            araddr  <= inst_sram_addr;
        end else if (arready) begin
            arvalid <= 1'b0;
        end
    end

    // Outstanding reads; a stray response at zero never underflows.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (accept && !r_retire) begin
            cnt <= cnt + CW'(1);
        end else if (!accept && r_retire) begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed bench for inst_axi_rd_bridge with MAX_OUTSTANDING=2.
module tb_inst_axi_rd_bridge;

    logic        clk;
    logic        resetn;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int n_pass;
    int n_total;

    inst_axi_rd_bridge #(.MAX_OUTSTANDING(2), .AXI_ID(4'h0)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .arid              (arid),
        .araddr            (araddr),
        .arlen             (arlen),
        .arsize            (arsize),
        .arburst           (arburst),
        .arlock            (arlock),
        .arcache           (arcache),
        .arprot            (arprot),
        .arvalid           (arvalid),
        .arready           (arready),
        .rid               (rid),
        .rdata             (rdata),
        .rresp             (rresp),
        .rlast             (rlast),
        .rvalid            (rvalid),
        .rready            (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Inputs change at the falling edge; outputs are sampled 1ns later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        resetn = 1'b0;
        inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd2;
        inst_sram_wstrb = 4'h0; inst_sram_addr = 32'd0; inst_sram_wdata = 32'd0;
        arready = 1'b0; rid = 4'h0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b1; rvalid = 1'b0;

        // Reset: 3 cycles, a request during reset is not accepted
        cyc(); cyc(); cyc();
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0000; settle();
        chk("rst_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_cnt", 32'(dut.cnt), 32'd0);
        chk("const_ar", {arid, arlen, arsize, arburst, arlock, arcache, arprot, 6'd0},
            {4'h0, 8'h00, 3'b010, 2'b01, 2'b00, 4'h0, 3'b000, 6'd0});

        // First cycle after release: rready not yet up, so no accept
        cyc(); resetn = 1'b1; inst_sram_req = 1'b0; settle();
        chk("rel_rready0", 32'(rready), 32'd0);
        cyc(); settle();
        chk("rel_rready1", 32'(rready), 32'd1);

        // Single fetch
        cyc(); inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0000; arready = 1'b1; settle();
        chk("sf_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
        cyc(); inst_sram_req = 1'b0; settle();
        chk("sf_arvalid", 32'(arvalid), 32'd1);
        chk("sf_araddr", araddr, 32'h1C00_0000);
        chk("sf_cnt1", 32'(dut.cnt), 32'd1);
        cyc(); rvalid = 1'b1; rdata = 32'h0280_0000; settle();
        chk("sf_arvalid_drop", 32'(arvalid), 32'd0);
        chk("sf_data_ok", 32'(inst_sram_data_ok), 32'd1);
        chk("sf_rdata", inst_sram_rdata, 32'h0280_0000);
        cyc(); rvalid = 1'b0; settle();
        chk("sf_cnt0", 32'(dut.cnt), 32'd0);
        chk("sf_data_ok0", 32'(inst_sram_data_ok), 32'd0);

        // AR stall: accept 0x1C000004, arready low for 4 cycles
        cyc(); inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0004; arready = 1'b0; settle();
        chk("st_accept", 32'(inst_sram_addr_ok), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(); inst_sram_addr = 32'h1C00_0008; settle();
            chk($sformatf("st_hold_v%0d", i), 32'(arvalid), 32'd1);
            chk($sformatf("st_hold_a%0d", i), araddr, 32'h1C00_0004);
            chk($sformatf("st_block%0d", i), 32'(inst_sram_addr_ok), 32'd0);
        end
        cyc(); arready = 1'b1; settle();
        chk("st_release_accept", 32'(inst_sram_addr_ok), 32'd1);
        cyc(); inst_sram_req = 1'b0; settle();
        chk("st_araddr2", araddr, 32'h1C00_0008);
        chk("st_cnt2", 32'(dut.cnt), 32'd2);

        // Full: AR slot free but two reads outstanding
        cyc(); inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_000C; settle();
        chk("full_arvalid0", 32'(arvalid), 32'd0);
        chk("full_block", 32'(inst_sram_addr_ok), 32'd0);
        cyc(); rvalid = 1'b1; rdata = 32'h0000_000A; settle();
        chk("full_dok_a", 32'(inst_sram_data_ok), 32'd1);
        chk("full_rdata_a", inst_sram_rdata, 32'h0000_000A);
        chk("full_same_cycle_block", 32'(inst_sram_addr_ok), 32'd0);
        // Accept and response together with cnt=1
        cyc(); rdata = 32'h0000_000B; settle();
        chk("full_cnt1", 32'(dut.cnt), 32'd1);
        chk("full_resume", 32'(inst_sram_addr_ok), 32'd1);
        chk("full_dok_b", 32'(inst_sram_data_ok), 32'd1);
        chk("full_rdata_b", inst_sram_rdata, 32'h0000_000B);
        cyc(); rvalid = 1'b0; inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0010; settle();
        chk("sim_cnt_stays", 32'(dut.cnt), 32'd1);
        chk("sim_araddr", araddr, 32'h1C00_000C);
        chk("sim_accept2", 32'(inst_sram_addr_ok), 32'd1);

        // Reset mid-operation with arvalid=1, cnt=2
        cyc(); resetn = 1'b0; arready = 1'b0; settle();
        chk("mr_pre_cnt", 32'(dut.cnt), 32'd2);
        chk("mr_pre_arvalid", 32'(arvalid), 32'd1);
        chk("mr_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
        cyc(); settle();
        chk("mr_arvalid", 32'(arvalid), 32'd0);
        chk("mr_cnt", 32'(dut.cnt), 32'd0);
        chk("mr_araddr", araddr, 32'd0);
        chk("mr_rready", 32'(rready), 32'd0);
        chk("mr_addr_ok2", 32'(inst_sram_addr_ok), 32'd0);
        cyc(); resetn = 1'b1; inst_sram_req = 1'b0; settle();
        cyc(); inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0020; arready = 1'b1; settle();
        chk("mr_fresh_accept", 32'(inst_sram_addr_ok), 32'd1);
        cyc(); inst_sram_req = 1'b0; settle();
        chk("mr_fresh_araddr", araddr, 32'h1C00_0020);
        cyc(); rvalid = 1'b1; rdata = 32'h1234_5678; settle();
        chk("mr_fresh_rdata", inst_sram_rdata, 32'h1234_5678);
        chk("mr_fresh_dok", 32'(inst_sram_data_ok), 32'd1);
        cyc(); rvalid = 1'b0; settle();
        chk("mr_fresh_cnt0", 32'(dut.cnt), 32'd0);

        // Write rejection
        for (int i = 0; i < 5; i++) begin
            cyc(); inst_sram_req = 1'b1; inst_sram_wr = 1'b1; inst_sram_addr = 32'h1C00_0040; settle();
            chk($sformatf("wr_addr_ok%0d", i), 32'(inst_sram_addr_ok), 32'd0);
            chk($sformatf("wr_arvalid%0d", i), 32'(arvalid), 32'd0);
        end

        // Stray response with nothing outstanding
        cyc(); inst_sram_req = 1'b0; inst_sram_wr = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; settle();
        chk("stray_dok", 32'(inst_sram_data_ok), 32'd1);
        cyc(); rvalid = 1'b0; settle();
        chk("stray_cnt0", 32'(dut.cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
